memory_access: RTL and testbench

Memory stage of the rv32i minimum core, directly upstream of write_back. It accepts one instruction at a time from execute and performs any LB/LH/LW/LBU/LHU or SB/SH/SW access over a req/ack data-memory interface. It produces the register-file write (rd, data, enable) that write_back consumes. Non-memory instructions pass through with their ALU result.

---
 rtl/memory_access_if.sv | 12 +
 rtl/memory_access.sv | 115 +++++++++++
 tb/tb_memory_access.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// memory_access_if: req/ack data-memory bus; master = memory_access, slave = memory
interface memory_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_rdata, mem_ack);
endinterface

// File: rtl/memory_access.sv
// memory_access: rv32i memory stage; in_* from execute, mem bus to data memory, wb_* to write_back
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  memory_access_if.master mem,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        error
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        wr_q;
  logic        is_mem, bad;
  logic [3:0]  be;
  logic [31:0] wdata, sh, ld;
  assign in_ready = state == IDLE;
  always_comb begin
    is_mem = is_load | is_store;
    bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 ||
          (funct3[1:0] == 2'b01 && alu_result[0]) ||
          (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
    be = funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 << alu_result[1:0] : 4'b0001 << alu_result[1:0];
    wdata = funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
    sh = mem.mem_rdata >> {off_q, 3'b000};
    // funct3[2] marks the unsigned variants, which suppresses sign extension
    ld = f3_q[1] ? sh :
         f3_q[0] ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} :
                   {{24{sh[7] & ~f3_q[2]}}, sh[7:0]};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      f3_q <= '0;
      off_q <= '0;
      wr_q <= 1'b0;
      mem.mem_req <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be <= '0;
      wb_valid <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          wb_rd <= rd;
          if (!is_mem) begin
            wb_data <= alu_result;
            wb_reg_write <= reg_write;
            wb_valid <= 1'b1;
            state <= RESP;
          end else if (bad) begin
            wb_data <= '0;
            error <= 1'b1;
            wb_valid <= 1'b1;
            state <= RESP;
          end else begin
            mem.mem_req <= 1'b1;
            mem.mem_we <= is_store;
            mem.mem_addr <= {alu_result[31:2], 2'b00};
            mem.mem_be <= be;
            mem.mem_wdata <= wdata;
            f3_q <= funct3;
            off_q <= alu_result[1:0];
            wr_q <= !is_store && rd != 5'd0;
            cnt <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: if (mem.mem_ack) begin
          mem.mem_req <= 1'b0;
          wb_data <= ld;
          wb_reg_write <= wr_q;
          wb_valid <= 1'b1;
          state <= RESP;
        end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          mem.mem_req <= 1'b0;
          wb_data <= '0;
          error <= 1'b1;
          wb_valid <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESP: begin
          wb_valid <= 1'b0;
          wb_reg_write <= 1'b0;
          error <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboard bench for memory_access
module tb_memory_access;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0;
  logic        wb_valid, wb_reg_write, error;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [4:0] rd; logic [31:0] data; logic rw; logic err; logic chk;} exp_t;
  exp_t q[$];
  always #5 clock = ~clock;
  memory_access_if mif();
  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .rd(rd),
    .reg_write(reg_write), .alu_result(alu_result), .store_data(store_data),
    .mem(mif), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .error(error)
  );
  always @(negedge clock) begin
    if (!reset && wb_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wb: wb_valid=1 rd=%0d with nothing expected", wb_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wb_rd !== e.rd || wb_reg_write !== e.rw || error !== e.err || (e.chk && wb_data !== e.data)) begin
          errors++;
          $display("FAIL wb_result: got rd=%0d rw=%b err=%b data=%h, expected rd=%0d rw=%b err=%b data=%h",
                   wb_rd, wb_reg_write, error, wb_data, e.rd, e.rw, e.err, e.data);
        end
      end
    end
  end
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [7:0] b;
    logic [15:0] h;
    case (off)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'h0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return d;
    endcase
  endfunction
  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00: case (off)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
      2'b01: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction
  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00: return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      2'b01: return {sd[15:0], sd[15:0]};
      default: return sd;
    endcase
  endfunction
  task automatic drive(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] r,
                       input logic rw, input logic [31:0] a, input logic [31:0] sd);
    @(negedge clock);
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; rd = r;
    reg_write = rw; alu_result = a; store_data = sd;
    @(negedge clock);
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++;
    if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus: got req=%b we=%b be=%b addr=%h wd=%h expected all 0",
                         mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata);
    end
    checks++;
    if ({wb_valid, wb_reg_write, error, wb_rd, wb_data} !== '0) begin
      errors++; $display("FAIL reset_wb: got v=%b rw=%b err=%b rd=%0d data=%h expected all 0",
                         wb_valid, wb_reg_write, error, wb_rd, wb_data);
    end
  endtask
  task automatic test_passthrough;
    q.push_back(exp_t'{5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 32'h0000_1234, 32'h0);
    checks++;
    if (wb_valid !== 1'b1 || in_ready !== 1'b0 || mif.mem_req !== 1'b0) begin
      errors++; $display("FAIL pass_latency: got v=%b ready=%b req=%b expected 1 0 0", wb_valid, in_ready, mif.mem_req);
    end
    @(negedge clock);
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pass_end: got v=%b ready=%b expected 0 1", wb_valid, in_ready);
    end
  endtask
  task automatic test_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                           input logic [3:0] be_req, input logic [31:0] d_req);
    q.push_back(exp_t'{5'd7, d_req, 1'b1, 1'b0, 1'b1});
    drive(1'b1, 1'b0, f3, 5'd7, 1'b0, a, 32'h0);
    checks++;
    if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0 || mif.mem_addr !== {a[31:2], 2'b00}) begin
      errors++; $display("FAIL load_req: got req=%b we=%b addr=%h expected 1 0 %h",
                         mif.mem_req, mif.mem_we, mif.mem_addr, {a[31:2], 2'b00});
    end
    checks++;
    if (mif.mem_be !== be_req) begin errors++; $display("FAIL load_be: got %b expected %b", mif.mem_be, be_req); end
    @(negedge clock);
    checks++;
    if (mif.mem_req !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL load_hold: got req=%b ready=%b expected 1 0", mif.mem_req, in_ready);
    end
    mif.mem_rdata = rdata; mif.mem_ack = 1'b1;
    @(negedge clock);
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'hA5A5_A5A5;
    checks++;
    if (mif.mem_req !== 1'b0 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL load_done: got req=%b v=%b expected 0 1", mif.mem_req, wb_valid);
    end
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL load_idle: got ready=%b v=%b expected 1 0", in_ready, wb_valid);
    end
  endtask
  task automatic test_store;
    q.push_back(exp_t'{5'd3, 32'h0, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 1'b1, 3'b001, 5'd3, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF);
    checks++;
    if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 || mif.mem_addr !== 32'h200) begin
      errors++; $display("FAIL sh_req: got req=%b we=%b addr=%h expected 1 1 00000200", mif.mem_req, mif.mem_we, mif.mem_addr);
    end
    checks++;
    if (mif.mem_be !== 4'b1100 || mif.mem_wdata !== 32'hBEEF_BEEF) begin
      errors++; $display("FAIL sh_lane: got be=%b wd=%h expected 1100 beefbeef", mif.mem_be, mif.mem_wdata);
    end
    mif.mem_ack = 1'b1;
    @(negedge clock);
    mif.mem_ack = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_load_x0;
    q.push_back(exp_t'{5'd0, 32'h0, 1'b0, 1'b0, 1'b0});
    drive(1'b1, 1'b0, 3'b010, 5'd0, 1'b1, 32'h0000_0600, 32'h0);
    checks++;
    if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL x0_access: got req=%b expected 1", mif.mem_req); end
    mif.mem_rdata = 32'h1357_9BDF; mif.mem_ack = 1'b1;
    @(negedge clock);
    mif.mem_ack = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_misaligned;
    logic [2:0]  f3s[4] = '{3'b010, 3'b001, 3'b101, 3'b011};
    logic [31:0] as[4]  = '{32'h301, 32'h105, 32'h10B, 32'h100};
    logic        sts[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      q.push_back(exp_t'{5'd9, 32'h0, 1'b0, 1'b1, 1'b0});
      drive(~sts[i], sts[i], f3s[i], 5'd9, 1'b1, as[i], 32'h0);
      checks++;
      if (mif.mem_req !== 1'b0 || wb_valid !== 1'b1 || error !== 1'b1) begin
        errors++; $display("FAIL misaligned_%0d: got req=%b v=%b err=%b expected 0 1 1", i, mif.mem_req, wb_valid, error);
      end
      @(negedge clock);
      checks++;
      if (mif.mem_req !== 1'b0 || in_ready !== 1'b1 || error !== 1'b0) begin
        errors++; $display("FAIL misaligned_end_%0d: got req=%b ready=%b err=%b expected 0 1 0", i, mif.mem_req, in_ready, error);
      end
    end
  endtask
  task automatic test_timeout;
    int req_cycles = 0;
    int wb_at = -1;
    logic ready_after = 1'b0;
    q.push_back(exp_t'{5'd1, 32'h0, 1'b0, 1'b1, 1'b0});
    drive(1'b1, 1'b0, 3'b010, 5'd1, 1'b0, 32'h0000_0400, 32'h0);
    if (mif.mem_req === 1'b1) req_cycles++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (mif.mem_req === 1'b1) req_cycles++;
      if (wb_valid === 1'b1 && wb_at < 0) wb_at = i;
      if (wb_at >= 0 && i == wb_at + 1) ready_after = in_ready;
    end
    checks++;
    if (req_cycles != 4) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles); end
    checks++;
    if (wb_at != 3) begin errors++; $display("FAIL timeout_wb_cycle: got %0d expected 3", wb_at); end
    checks++;
    if (ready_after !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b expected 1", ready_after); end
  endtask
  task automatic test_back_to_back;
    logic        lds[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 1};
    logic        sts[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [2:0]  f3s[9] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010, 3'b000, 3'b010, 3'b001, 3'b000};
    logic [31:0] as[9]  = '{32'h102, 32'h106, 32'h101, 32'h102, 32'h10C, 32'h203, 32'h208, 32'h200, 32'h201};
    for (int i = 0; i < 9; i++) begin
      logic [31:0] rdata, sd;
      int n;
      rdata = $urandom;
      sd = $urandom;
      if (i == 0) rdata = 32'h1234_8000;
      q.push_back(exp_t'{5'(i + 10), exp_load(f3s[i], as[i][1:0], rdata), ~sts[i], 1'b0, ~sts[i]});
      drive(lds[i], sts[i], f3s[i], 5'(i + 10), 1'b1, as[i], sd);
      n = 0;
      while (mif.mem_req !== 1'b1 && n < 8) begin @(negedge clock); n++; end
      checks++;
      if (n != 0) begin errors++; $display("FAIL b2b_req_%0d: req arrived after %0d extra cycles, expected 0", i, n); end
      checks++;
      if (mif.mem_we !== sts[i] || mif.mem_addr !== {as[i][31:2], 2'b00} || mif.mem_be !== exp_be(f3s[i], as[i][1:0])) begin
        errors++; $display("FAIL b2b_bus_%0d: got we=%b addr=%h be=%b expected %b %h %b", i, mif.mem_we, mif.mem_addr,
                           mif.mem_be, sts[i], {as[i][31:2], 2'b00}, exp_be(f3s[i], as[i][1:0]));
      end
      if (sts[i]) begin
        checks++;
        if (mif.mem_wdata !== exp_wd(f3s[i], sd)) begin
          errors++; $display("FAIL b2b_wdata_%0d: got %h expected %h", i, mif.mem_wdata, exp_wd(f3s[i], sd));
        end
      end
      mif.mem_rdata = rdata; mif.mem_ack = 1'b1;
      @(negedge clock);
      mif.mem_ack = 1'b0;
    end
    @(negedge clock);
  endtask
  task automatic test_reset_mid;
    int stray = 0;
    drive(1'b1, 1'b0, 3'b010, 5'd2, 1'b0, 32'h0000_0500, 32'h0);
    checks++;
    if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL midreset_req: got %b expected 1", mif.mem_req); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (mif.mem_req !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got req=%b ready=%b v=%b expected 0 1 0", mif.mem_req, in_ready, wb_valid);
    end
    reset = 1'b0;
    mif.mem_rdata = 32'hFFFF_FFFF; mif.mem_ack = 1'b1;
    @(negedge clock);
    mif.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid !== 1'b0 || mif.mem_req !== 1'b0) stray++;
      @(negedge clock);
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL stray_ack: got %0d active cycles expected 0", stray); end
  endtask
  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    test_reset;
    test_passthrough;
    test_load(3'b000, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    test_load(3'b100, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    test_store;
    test_load_x0;
    test_misaligned;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
